// File: rtl/spi_resp_tx_if.sv
// spi_resp_tx_if: enqueue handshake and status flags between internal logic and the SPI response transmitter
interface spi_resp_tx_if #(parameter int DEPTH = 4);
  logic [7:0] tx_data;
  logic tx_valid, tx_ready, byte_done, underflow, abort;
  logic [$clog2(DEPTH):0] level;
  modport master(output tx_data, tx_valid, input tx_ready, level, byte_done, underflow, abort);
  modport slave(input tx_data, tx_valid, output tx_ready, level, byte_done, underflow, abort);
endinterface

// File: rtl/spi_resp_tx.sv
// spi_resp_tx: SPI mode-0 slave transmitter shifting queued response bytes out MSB-first on sdo
module spi_resp_tx #(
  parameter int DEPTH = 4,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs,
  output logic sdo,
  spi_resp_tx_if.slave tx
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [2:0] sck_q, cs_q;
  logic rise_q, fall_q, csf_q, csr_q;
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] level_q, level_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic fresh_q, fresh_d, bd_q, bd_d, uf_q, uf_d, ab_q, ab_d;
  logic load, push, pop, flush;
  assign push = tx.tx_valid && tx.tx_ready;
  assign pop = load && level_q != '0;
  assign level_d = flush ? {{AW{1'b0}}, push} : level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign tx.tx_ready = level_q != (AW+1)'(DEPTH);
  assign tx.level = level_q;
  assign tx.byte_done = bd_q;
  assign tx.underflow = uf_q;
  assign tx.abort = ab_q;
  assign sdo = state_q == SHIFT && shreg_q[7];
  // [0],[1] synchronise the pin, [2] is the edge-detect history
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sck_q <= 3'b000;
      cs_q <= 3'b111;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      csf_q <= 1'b0;
      csr_q <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      cs_q <= {cs_q[1:0], cs};
      rise_q <= sck_q[1] && !sck_q[2];
      fall_q <= !sck_q[1] && sck_q[2];
      csf_q <= !cs_q[1] && cs_q[2];
      csr_q <= cs_q[1] && !cs_q[2];
    end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= tx.tx_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      shreg_q <= '0;
      cnt_q <= '0;
      fresh_q <= 1'b0;
      bd_q <= 1'b0;
      uf_q <= 1'b0;
      ab_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= push ? wptr_q + 1'b1 : wptr_q;
      rptr_q <= flush ? wptr_q : pop ? rptr_q + 1'b1 : rptr_q;
      level_q <= level_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      fresh_q <= fresh_d;
      bd_q <= bd_d;
      uf_q <= uf_d;
      ab_q <= ab_d;
    end
  // a mid-byte deselect aborts the whole response, so the queue is flushed with it
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
    fresh_d = fresh_q;
    bd_d = 1'b0;
    uf_d = 1'b0;
    ab_d = 1'b0;
    load = 1'b0;
    flush = 1'b0;
    if (state_q == IDLE) begin
      cnt_d = '0;
      load = csf_q;
      state_d = csf_q ? SHIFT : IDLE;
    end else if (csr_q) begin
      state_d = IDLE;
      cnt_d = '0;
      ab_d = cnt_q != '0;
      flush = cnt_q != '0;
    end else if (rise_q) begin
      cnt_d = cnt_q + 3'd1;
      bd_d = cnt_q == 3'd7;
      fresh_d = 1'b0;
    end else if (fall_q) begin
      shreg_d = cnt_q != '0 ? {shreg_q[6:0], 1'b0} : shreg_q;
      load = cnt_q == '0 && !fresh_q;
    end
    if (load) begin
      shreg_d = level_q != '0 ? mem_q[rptr_q] : IDLE_BYTE;
      uf_d = level_q == '0;
      fresh_d = 1'b1;
    end
  end
endmodule
